// File: rtl/my_top_level.sv
// rtl/my_top_level.sv - LATENCY-stage pipelined unsigned adder, io_X = (io_A + io_B) mod 2^WIDTH
module my_top_level #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  output logic [WIDTH-1:0] io_X
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_stage [LATENCY];

  // The carry-out is dropped on purpose: results wrap modulo 2^WIDTH.
  assign w_sum = io_A + io_B;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= w_sum;
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign io_X = r_stage[LATENCY-1];

endmodule

// File: tb/tb_my_top_level.sv
// tb/tb_my_top_level.sv - scoreboard bench for my_top_level (8-bit/L1 and 4-bit/L3 instances)
module tb_my_top_level;

  localparam int L8 = 1;
  localparam int L4 = 3;

  typedef struct {
    int         due;
    logic [7:0] val;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst8, rst4;
  logic [7:0] a8, b8, x8;
  logic [3:0] a4, b4, x4;

  int   ecnt = 0;
  int   tests = 0;
  int   fails = 0;
  bit   done4 = 1'b0;
  bit   end_req = 1'b0;
  bit   end_done = 1'b0;
  bit   prev8 = 1'b0;
  bit   prev4 = 1'b0;
  exp_t q8[$];
  exp_t q4[$];

  my_top_level #(.WIDTH(8), .LATENCY(L8)) u_dut8 (
    .clk(clk), .reset(rst8), .io_A(a8), .io_B(b8), .io_X(x8)
  );

  my_top_level #(.WIDTH(4), .LATENCY(L4)) u_dut4 (
    .clk(clk), .reset(rst4), .io_A(a4), .io_B(b4), .io_X(x4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Drives one cycle of the 8-bit instance and records what io_X must show after that edge.
  task automatic drive8(input bit r, input logic [7:0] a, input logic [7:0] b, input string tag);
    int   nxt;
    exp_t e;
    logic [7:0] s;
    nxt = ecnt + 1;
    rst8 = r; a8 = a; b8 = b;
    if (r) begin
      while (q8.size() > 0 && q8[$].due >= nxt) void'(q8.pop_back());
      e.due = nxt; e.val = 8'h00; e.tag = "rst8_zero"; q8.push_back(e);
    end else begin
      if (prev8) begin
        for (int j = 0; j < L8 - 1; j++) begin
          e.due = nxt + j; e.val = 8'h00; e.tag = "fill8_zero"; q8.push_back(e);
        end
      end
      s = a + b;
      e.due = nxt + L8 - 1; e.val = s; e.tag = tag; q8.push_back(e);
    end
    prev8 = r;
    @(posedge clk); #1;
  endtask

  task automatic drive4(input bit r, input logic [3:0] a, input logic [3:0] b, input logic [3:0] x, input string tag);
    int   nxt;
    exp_t e;
    nxt = ecnt + 1;
    rst4 = r; a4 = a; b4 = b;
    if (r) begin
      while (q4.size() > 0 && q4[$].due >= nxt) void'(q4.pop_back());
      e.due = nxt; e.val = 8'h00; e.tag = "rst4_zero"; q4.push_back(e);
    end else begin
      if (prev4) begin
        for (int j = 0; j < L4 - 1; j++) begin
          e.due = nxt + j; e.val = 8'h00; e.tag = "fill4_zero"; q4.push_back(e);
        end
      end
      e.due = nxt + L4 - 1; e.val = {4'h0, x}; e.tag = tag; q4.push_back(e);
    end
    prev4 = r;
    @(posedge clk); #1;
  endtask

  // Monitor: sole owner of the pass/fail counters.
  always @(negedge clk) begin
    exp_t e;
    while (q8.size() > 0 && q8[0].due <= ecnt) begin
      e = q8.pop_front();
      tests++;
      if (e.due != ecnt || x8 !== e.val) begin
        fails++;
        $display("FAIL %s edge=%0d due=%0d actual=%02h required=%02h", e.tag, ecnt, e.due, x8, e.val);
      end
    end
    while (q4.size() > 0 && q4[0].due <= ecnt) begin
      e = q4.pop_front();
      tests++;
      if (e.due != ecnt || {4'h0, x4} !== e.val) begin
        fails++;
        $display("FAIL %s edge=%0d due=%0d actual=%01h required=%01h", e.tag, ecnt, e.due, x4, e.val[3:0]);
      end
    end
    if (end_req && !end_done) begin
      tests++;
      if (!done4) begin
        fails++;
        $display("FAIL w4_timeout actual=not_done required=done");
      end
      tests++;
      if (q8.size() + q4.size() != 0) begin
        fails++;
        $display("FAIL queue_drain actual=%0d required=0", q8.size() + q4.size());
      end
      end_done = 1'b1;
    end
  end

  // 4-bit / 3-stage instance: wrap, fill zeros, mid-stream reset.
  initial begin
    for (int i = 0; i < 5; i++) drive4(1'b1, 4'hF, 4'h2, 4'h0, "");
    drive4(1'b0, 4'hF, 4'h2, 4'h1, "w4_F_plus_2");
    drive4(1'b0, 4'h7, 4'h8, 4'hF, "w4_7_plus_8");
    drive4(1'b0, 4'h9, 4'h9, 4'h2, "w4_9_plus_9");
    drive4(1'b0, 4'h3, 4'h4, 4'h7, "w4_3_plus_4");
    drive4(1'b1, 4'h5, 4'h5, 4'h0, "");
    drive4(1'b0, 4'h8, 4'h8, 4'h0, "w4_8_plus_8");
    drive4(1'b0, 4'hA, 4'h3, 4'hD, "w4_A_plus_3");
    for (int i = 0; i < 4; i++) drive4(1'b0, 4'h0, 4'h0, 4'h0, "w4_zero");
    done4 = 1'b1;
  end

  // 8-bit / 1-stage instance and test sequencing.
  initial begin
    int k;
    logic [7:0] ra, rb;
    for (int i = 0; i < 10; i++) drive8(1'b1, 8'h37, 8'h21, "");
    drive8(1'b0, 8'h37, 8'h21, "release_58");
    for (k = 0; k < 100; k++) begin
      if (k == 60) drive8(1'b1, 8'(k), 8'(k), "");
      drive8(1'b0, 8'(k), 8'(k), "ramp");
    end
    drive8(1'b0, 8'hFF, 8'h01, "wrap_FF_01");
    drive8(1'b0, 8'hC8, 8'h64, "wrap_C8_64");
    drive8(1'b0, 8'hFF, 8'hFF, "wrap_FF_FF");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      drive8(1'b0, ra, rb, "random");
    end
    for (int i = 0; i < 2000 && !done4; i++) @(posedge clk);
    repeat (L8 + L4 + 2) @(posedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
    if (!end_done) begin
      $display("FAIL monitor_end actual=no_response required=response");
      $fatal(1, "monitor did not complete");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
